// File: rtl/hfusion_pkg.sv
// hfusion_pkg: shared constants and width helpers for the fusion blend pipe
package hfusion_pkg;
  localparam int DEF_LOG2_NO_OF_IMAGES = 4;
  localparam int NO_OF_IMAGES = 1 << DEF_LOG2_NO_OF_IMAGES;
  localparam int DEF_NUM_W = 35;
  localparam int DEF_DEN_W = 31;
  localparam int DEF_WGT_W = 8;
  localparam int WMAX = 1 << DEF_WGT_W;
  localparam int WHALF = 1 << (DEF_WGT_W - 1);
  function automatic int prod_w(input int num_w, input int den_w);
    return num_w + den_w;
  endfunction
  function automatic int wmax(input int wgt_w);
    return 1 << wgt_w;
  endfunction
  function automatic int whalf(input int wgt_w);
    return 1 << (wgt_w - 1);
  endfunction
  localparam int PROD_W = prod_w(DEF_NUM_W, DEF_DEN_W);
endpackage

// File: rtl/hfusion_blend_pipe_if.sv
// hfusion_blend_pipe_if: pixel/score input stream, blended output stream and sequence restart
interface hfusion_blend_pipe_if import hfusion_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int NCH = 1,
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W,
  parameter int LOG2_NO_OF_IMAGES = DEF_LOG2_NO_OF_IMAGES
);
  logic seq_restart;
  logic s_valid, s_ready;
  logic [NCH*PIX_W-1:0] s_fuse, s_new;
  logic signed [NUM_W-1:0] s_fuse_numr, s_new_numr;
  logic signed [DEN_W-1:0] s_fuse_deno, s_new_deno;
  logic m_valid, m_ready;
  logic [NCH*PIX_W-1:0] m_pix;
  logic m_last;
  logic [LOG2_NO_OF_IMAGES-1:0] m_img_idx;
  modport master (
    output seq_restart, s_valid, s_fuse, s_new, s_fuse_numr, s_fuse_deno, s_new_numr, s_new_deno, m_ready,
    input s_ready, m_valid, m_pix, m_last, m_img_idx
  );
  modport slave (
    input seq_restart, s_valid, s_fuse, s_new, s_fuse_numr, s_fuse_deno, s_new_numr, s_new_deno, m_ready,
    output s_ready, m_valid, m_pix, m_last, m_img_idx
  );
endinterface

// File: rtl/hfusion_row_smooth.sv
// hfusion_row_smooth: 1-2-1 decision window with edge replication and row-end flush (used with HFUSION_SMOOTH_EN)
module hfusion_row_smooth import hfusion_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int NCH = 1,
  parameter int WGT_W = DEF_WGT_W,
  parameter int IM_LEN = 520,
  parameter int LOG2_NO_OF_IMAGES = DEF_LOG2_NO_OF_IMAGES,
  parameter int CW = $clog2(IM_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic acc_end,
  input  logic in_v,
  input  logic in_f,
  input  logic in_d,
  input  logic [CW-1:0] in_col,
  input  logic [NCH*PIX_W-1:0] in_fu,
  input  logic [NCH*PIX_W-1:0] in_nw,
  input  logic [LOG2_NO_OF_IMAGES-1:0] in_img,
  input  logic in_last,
  output logic flush,
  output logic o_v,
  output logic [WGT_W:0] o_wf,
  output logic [NCH*PIX_W-1:0] o_fu,
  output logic [NCH*PIX_W-1:0] o_nw,
  output logic [LOG2_NO_OF_IMAGES-1:0] o_img,
  output logic o_last
);
  logic shift, w_v, w_d, p_d, l, r;
  logic [CW-1:0] w_col;
  logic [2:0] sum;
  assign shift = en & (in_v | in_f);
  assign o_v = w_v & (in_v | in_f);
  // one bubble beat after the last column lets the window emit it; holds until the pipe moves
  always_ff @(posedge clk or posedge rst)
    if (rst) flush <= 1'b0;
    else if (acc_end) flush <= 1'b1;
    else if (en) flush <= 1'b0;
  // centre sample plus previous decision; only real or flush beats shift, so gaps keep neighbours adjacent
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_d <= 1'b0;
      w_v <= 1'b0;
      w_d <= 1'b0;
      w_col <= '0;
      o_fu <= '0;
      o_nw <= '0;
      o_img <= '0;
      o_last <= 1'b0;
    end else if (shift) begin
      p_d <= w_d;
      w_v <= in_v;
      w_d <= in_d;
      w_col <= in_col;
      o_fu <= in_fu;
      o_nw <= in_nw;
      o_img <= in_img;
      o_last <= in_last;
    end
  // missing neighbours at either row end replicate the centre decision
  always_comb begin
    l = w_col == '0 ? w_d : p_d;
    r = w_col == CW'(IM_LEN - 1) ? w_d : in_d;
    sum = 3'(l) + {1'b0, w_d, 1'b0} + 3'(r);
    o_wf = {sum, (WGT_W - 2)'(0)};
  end
endmodule

// File: rtl/hfusion_blend_pipe.sv
// hfusion_blend_pipe: SSIM-driven fused/new pixel select and blend; HFUSION_SMOOTH_EN adds horizontal decision smoothing
module hfusion_blend_pipe import hfusion_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int NCH = 1,
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W,
  parameter int WGT_W = DEF_WGT_W,
  parameter int IM_LEN = 520,
  parameter int IM_WID = 520,
  parameter int LOG2_NO_OF_IMAGES = DEF_LOG2_NO_OF_IMAGES
) (
  input logic clk,
  input logic rst,
  hfusion_blend_pipe_if.slave bus
);
  localparam int PW = prod_w(NUM_W, DEN_W);
  localparam int CW = $clog2(IM_LEN);
  localparam int RW = $clog2(IM_WID);
  localparam int LW = LOG2_NO_OF_IMAGES;
  localparam int DW = NCH * PIX_W;
  localparam int AW = PIX_W + WGT_W + 2;
  localparam int WM = wmax(WGT_W);
  localparam int WH = whalf(WGT_W);
  logic en, acc, col_end, row_end;
  logic [CW-1:0] col, col_b;
  logic [RW-1:0] row, row_b;
  logic [LW-1:0] img, img_b;
  logic s1_v, s1_sx, s1_z, s1_last, s2_v, s2_d, s2_last, o_v, o_last;
  logic signed [PW-1:0] s1_p1, s1_p2;
  logic [DW-1:0] s1_fu, s1_nw, s2_fu, s2_nw, o_fu, o_nw, blend;
  logic [LW-1:0] s1_img, s2_img, o_img;
  logic [WGT_W:0] o_wf;
  assign en = bus.m_ready | ~bus.m_valid;
  assign acc = bus.s_valid & bus.s_ready;
  assign col_b = bus.seq_restart ? '0 : col;
  assign row_b = bus.seq_restart ? '0 : row;
  assign img_b = bus.seq_restart ? '0 : img;
  assign col_end = col_b == CW'(IM_LEN - 1);
  assign row_end = row_b == RW'(IM_WID - 1);
  // position counters; restart folds into the base so a coinciding beat is image 0 pixel 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      img <= '0;
    end else begin
      col <= acc ? (col_end ? '0 : col_b + 1'b1) : col_b;
      row <= acc & col_end ? (row_end ? '0 : row_b + 1'b1) : row_b;
      img <= acc & col_end & row_end ? img_b + 1'b1 : img_b;
    end
  // stage 1: cross products avoid dividing the SSIM ratios
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_p1 <= '0;
      s1_p2 <= '0;
      s1_sx <= 1'b0;
      s1_z <= 1'b0;
      s1_fu <= '0;
      s1_nw <= '0;
      s1_img <= '0;
      s1_last <= 1'b0;
    end else if (en) begin
      s1_v <= acc;
      s1_p1 <= PW'(bus.s_fuse_numr) * PW'(bus.s_new_deno);
      s1_p2 <= PW'(bus.s_new_numr) * PW'(bus.s_fuse_deno);
      s1_sx <= bus.s_fuse_deno[DEN_W-1] ^ bus.s_new_deno[DEN_W-1];
      s1_z <= img_b == '0;
      s1_fu <= bus.s_fuse;
      s1_nw <= bus.s_new;
      s1_img <= img_b;
      s1_last <= &img_b & row_end & col_end;
    end
  // stage 2: decision, flipped when exactly one denominator is negative; image 0 always takes new
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_v <= 1'b0;
      s2_d <= 1'b0;
      s2_fu <= '0;
      s2_nw <= '0;
      s2_img <= '0;
      s2_last <= 1'b0;
    end else if (en) begin
      s2_v <= s1_v;
      s2_d <= ~s1_z & ((s1_p1 > s1_p2) ^ s1_sx);
      s2_fu <= s1_fu;
      s2_nw <= s1_nw;
      s2_img <= s1_img;
      s2_last <= s1_last;
    end
`ifdef HFUSION_SMOOTH_EN
  logic flush, s1_f, s2_f;
  logic [CW-1:0] s1_col, s2_col;
  // flush marker and column ride alongside stages 1 and 2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_f <= 1'b0;
      s2_f <= 1'b0;
      s1_col <= '0;
      s2_col <= '0;
    end else if (en) begin
      s1_f <= flush;
      s2_f <= s1_f;
      s1_col <= col_b;
      s2_col <= s1_col;
    end
  hfusion_row_smooth #(
    .PIX_W(PIX_W), .NCH(NCH), .WGT_W(WGT_W), .IM_LEN(IM_LEN), .LOG2_NO_OF_IMAGES(LW)
  ) u_smooth (
    .clk(clk), .rst(rst), .en(en), .acc_end(acc & col_end),
    .in_v(s2_v), .in_f(s2_f), .in_d(s2_d), .in_col(s2_col),
    .in_fu(s2_fu), .in_nw(s2_nw), .in_img(s2_img), .in_last(s2_last),
    .flush(flush), .o_v(o_v), .o_wf(o_wf), .o_fu(o_fu), .o_nw(o_nw), .o_img(o_img), .o_last(o_last)
  );
  assign bus.s_ready = en & ~flush;
`else
  assign o_v = s2_v;
  assign o_wf = {s2_d, WGT_W'(0)};
  assign o_fu = s2_fu;
  assign o_nw = s2_nw;
  assign o_img = s2_img;
  assign o_last = s2_last;
  assign bus.s_ready = en;
`endif
  // rounded per-channel blend; full weight on one side keeps the result within PIX_W
  always_comb begin
    blend = '0;
    for (int i = 0; i < NCH; i++)
      blend[i*PIX_W +: PIX_W] = PIX_W'((AW'(o_wf) * AW'(o_fu[i*PIX_W +: PIX_W])
        + (AW'(WM) - AW'(o_wf)) * AW'(o_nw[i*PIX_W +: PIX_W]) + AW'(WH)) >> WGT_W);
  end
  // output register; payload only changes with a new valid pixel, so it holds under backpressure
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_pix <= '0;
      bus.m_last <= 1'b0;
      bus.m_img_idx <= '0;
    end else if (en) begin
      bus.m_valid <= o_v;
      if (o_v) begin
        bus.m_pix <= blend;
        bus.m_last <= o_last;
        bus.m_img_idx <= o_img;
      end
    end
endmodule

// File: tb/tb_hfusion_blend_pipe.sv
// tb_hfusion_blend_pipe: directed vectors with hand-computed blends, random backpressure, reset and restart
module tb_hfusion_blend_pipe;
  localparam int PIX_W = 8, NCH = 2, NUM_W = 35, DEN_W = 31, WGT_W = 8;
  localparam int IM_LEN = 8, IM_WID = 2, L = 2;
`ifdef HFUSION_SMOOTH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  typedef struct packed {logic [15:0] pix; logic [1:0] img; logic last;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd = 1'b0;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, first_acc = -1, first_out = -1, lasts = 0, outs = 0, cur_col = 0;
  bit stall_p = 0, flush_chk = 0;
  logic [15:0] pix_p;
  logic [1:0] img_p;
  logic last_p;
  logic [15:0] sp [8];
  always #5 clk = ~clk;
  hfusion_blend_pipe_if #(.PIX_W(PIX_W), .NCH(NCH), .NUM_W(NUM_W), .DEN_W(DEN_W), .LOG2_NO_OF_IMAGES(L)) bus ();
  hfusion_blend_pipe #(
    .PIX_W(PIX_W), .NCH(NCH), .NUM_W(NUM_W), .DEN_W(DEN_W), .WGT_W(WGT_W),
    .IM_LEN(IM_LEN), .IM_WID(IM_WID), .LOG2_NO_OF_IMAGES(L)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [15:0] fu, input logic [15:0] nw, input longint fn, input longint fd,
                      input longint nn, input longint nd, input logic [15:0] ex, input int img,
                      input int col, input bit last);
    int n = 0;
    exp_t e;
    e.pix = ex;
    e.img = 2'(img);
    e.last = last;
    q.push_back(e);
    cur_col = col;
    bus.s_valid = 1'b1;
    bus.s_fuse = fu;
    bus.s_new = nw;
    bus.s_fuse_numr = fn[NUM_W-1:0];
    bus.s_fuse_deno = fd[DEN_W-1:0];
    bus.s_new_numr = nn[NUM_W-1:0];
    bus.s_new_deno = nd[DEN_W-1:0];
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_ready && n < 200);
    if (n >= 200) chk("ready_timeout", bus.s_ready, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask
  task automatic row(input logic [15:0] fu, input logic [15:0] nw, input longint fn, input longint fd,
                     input longint nn, input longint nd, input logic [15:0] ex, input int img,
                     input bit lastrow, input int ncol);
    for (int c = 0; c < ncol; c++) beat(fu, nw, fn, fd, nn, nd, ex, img, c, lastrow && c == IM_LEN - 1);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_pix"}, bus.m_pix, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_m_img_idx"}, bus.m_img_idx, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1;
    bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk)
    if (rst) begin
      stall_p = 0;
      flush_chk = 0;
    end else begin
      if (flush_chk) begin
`ifdef HFUSION_SMOOTH_EN
        chk("flush_s_ready", bus.s_ready, 0);
`endif
        flush_chk = 0;
      end
      if (bus.s_valid && bus.s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        flush_chk = cur_col == IM_LEN - 1;
      end
      if (bus.m_valid && first_out < 0) first_out = cyc;
      if (stall_p) begin
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_pix", bus.m_pix, pix_p);
        chk("hold_img", bus.m_img_idx, img_p);
        chk("hold_last", bus.m_last, last_p);
      end
      stall_p = bus.m_valid && !bus.m_ready;
      pix_p = bus.m_pix;
      img_p = bus.m_img_idx;
      last_p = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        exp_t e;
        outs++;
        if (bus.m_last) lasts++;
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("pix", bus.m_pix, e.pix);
          chk("img_idx", bus.m_img_idx, e.img);
          chk("last", bus.m_last, e.last);
        end
      end
    end
  initial begin
`ifdef HFUSION_SMOOTH_EN
    sp = '{16'h0000, 16'h0000, 16'h4040, 16'h8080, 16'h4040, 16'h0000, 16'h0000, 16'h0000};
`else
    sp = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    bus.seq_restart = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_fuse = '0;
    bus.s_new = '0;
    bus.s_fuse_numr = '0;
    bus.s_fuse_deno = '0;
    bus.s_new_numr = '0;
    bus.s_new_deno = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rnd = 1'b1;
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h64C8, 1, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 3, 2, 10, 2, 16'h0A32, 1, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, -10, -2, 3, 2, 16'h64C8, 2, 0, IM_LEN);
    for (int c = 0; c < IM_LEN; c++)
      beat(16'hFFFF, 16'h0000, c == 3 ? 10 : 3, 2, c == 3 ? 3 : 10, 2, sp[c], 2, c, 0);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h64C8, 3, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 3, 2, 10, 2, 16'h0A32, 3, 1, IM_LEN);
    drain("drain_seq");
    chk("latency", first_out - first_acc, LAT);
    chk("last_count", lasts, 1);
    chk("out_count", outs, 64);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, 3);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    row(16'h4D4D, 16'h4D4D, 10, 2, 3, 2, 16'h4D4D, 1, 0, 4);
    bus.seq_restart = 1'b1;
    @(posedge clk);
    #1;
    bus.seq_restart = 1'b0;
    row(16'h64C8, 16'h0A32, 10, 2, 3, 2, 16'h0A32, 0, 0, IM_LEN);
    drain("drain_restart");
    chk("last_count_end", lasts, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hfusion_blend_pipe.md
Name: hfusion_blend_pipe

Overview:
Streaming, parametrised successor to the per-pixel fusion stage. It takes aligned fused/new pixels plus their SSIM numerator/denominator scores and decides per pixel which source wins, using cross-multiplication with sign correction. It can smooth the binary decision horizontally, then blends NCH channels with rounding. A valid/ready handshake with full-pipeline stall lets it sit between the SSIM engines and the frame writer under backpressure.

Parameters:
PIX_W, 8, bits per channel sample
NCH, 1, channels per pixel (all channels share one decision)
NUM_W, 35, signed SSIM numerator width
DEN_W, 31, signed SSIM denominator width
WGT_W, 8, blend weight fraction bits; weight range 0..2^WGT_W inclusive
IM_LEN, 520, pixels per row
IM_WID, 520, rows per image
LOG2_NO_OF_IMAGES, 4, images per fusion sequence = 2^LOG2_NO_OF_IMAGES

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
seq_restart  in  1  sync pulse: next accepted pixel is image 0, pixel 0
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_fuse  in  NCH*PIX_W  previous fused pixel
s_new  in  NCH*PIX_W  new image pixel
s_fuse_numr  in  NUM_W  signed SSIM numerator, fused
s_fuse_deno  in  DEN_W  signed SSIM denominator, fused
s_new_numr  in  NUM_W  signed SSIM numerator, new
s_new_deno  in  DEN_W  signed SSIM denominator, new
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_pix  out  NCH*PIX_W  blended pixel
m_last  out  1  last pixel of last image of sequence
m_img_idx  out  LOG2_NO_OF_IMAGES  image index of m_pix

Behaviour:
- Reset: m_valid=0, m_pix=0, m_last=0, m_img_idx=0, s_ready=1; counters, window and pipe registers cleared. Reset mid-frame discards in-flight data; the next beat is image 0, row 0, col 0.
- Global enable en = m_ready | ~m_valid. All stages advance only when en=1. s_ready = en & ~flush.
- Counters col/row/img advance per accepted beat. col wraps at IM_LEN-1, row at IM_WID-1, img at 2^L-1. seq_restart zeroes all three; if it coincides with an accepted beat, that beat is image 0, pixel 0.
- Stage 1 registers the products P1 = fuse_numr*new_deno and P2 = new_numr*fuse_deno, each NUM_W+DEN_W bits signed.
- Stage 2 computes d = (P1 > P2) XOR (fuse_deno[MSB] XOR new_deno[MSB]). d=1 means the fused pixel wins. Image 0 forces d=0.
- Smoothing stage: wf = (d[c-1] + 2*d[c] + d[c+1]) << (WGT_W-2). At col 0 and col IM_LEN-1 the missing neighbour replicates the centre sample.
- Row-end flush: the cycle after the col=IM_LEN-1 beat is accepted, flush=1 for exactly one enabled cycle. s_ready=0 during it while the window emits the last column; flush holds across stalls until en=1.
- Blend, per channel: out = (wf*fuse + (2^WGT_W - wf)*new + 2^(WGT_W-1)) >> WGT_W, computed exactly at PIX_W+WGT_W+2 bits. The result never exceeds 2^PIX_W-1, so no saturation is needed.
- Latency, no stalls: acceptance of pixel c to m_valid = 4 cycles, given pixel c+1 or the flush beat in the next cycle.
- m_last=1 with the pixel at img 2^L-1, row IM_WID-1, col IM_LEN-1. m_img_idx travels with each pixel.
- While m_valid=1 and m_ready=0, m_pix, m_last and m_img_idx hold stable.

Optional Feature:
HFUSION_SMOOTH_EN
- Defined: 3-tap smoothing plus row-end flush as specified above; latency 4.
- Undefined: wf = d << WGT_W, i.e. a hard select. No window stage and no flush, so s_ready = en always; latency 3.

Decomposition:
- Package hfusion_pkg: image-count and product-width constants, function prod_w(NUM_W,DEN_W), weight constants WMAX = 1<<WGT_W and WHALF.
- Sub-module hfusion_row_smooth holds the 3-entry decision window, edge replication and the flush/emit control, instantiated only under HFUSION_SMOOTH_EN.

Test Plan:
- Image 0, any scores, fuse=200, new=50 -> m_pix=50 for every pixel, m_img_idx=0.
- Image 1, all fused scores better (numr 10/deno 2 vs 3/2), smoothing off, fuse=200, new=50 -> m_pix=200; with scores swapped -> 50.
- One negative denominator (fuse_deno=-2, new_deno=2, fuse_numr=-10, new_numr=3) -> sign-corrected d=1, m_pix=fuse.
- Smoothing on, IM_LEN=8, row d=00010000, fuse=255, new=0, WGT_W=8 -> cols 2,3,4 give 64,128,64 (rounded); s_ready low one cycle after col 7.
- Random m_ready (50%) over a 4x4x2^L sequence -> no beat dropped or duplicated, outputs stable while stalled, exactly one m_last on the final pixel.
- Assert rst mid-row, then resume -> first post-reset output is image 0 passthrough; seq_restart pulse mid-image -> next pixel reported at m_img_idx=0.
